// File: rtl/spike_scheduler.sv
// Round-robin spike event scheduler: captures rising edges on each neuron's
// spike line, queues one pending event per neuron, offers them one at a time
// over a valid/ready port and holds each accepted neuron refractory for a
// fixed number of cycles.
module spike_scheduler #(
  parameter int N_NEURONS     = 4,
  parameter int ID_W          = 2,
  parameter int REFRAC_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [N_NEURONS-1:0] spike_in,
  output logic                 ev_valid,
  output logic [ID_W-1:0]      ev_id,
  input  logic                 ev_ready,
  output logic [N_NEURONS-1:0] inhibit,
  output logic [N_NEURONS-1:0] pending,
  output logic                 overflow,
  input  logic                 clr_ovf
);

  localparam logic [CNT_W-1:0] REFRAC_LD = CNT_W'(REFRAC_CYCLES);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                 state, state_nxt;
  logic [N_NEURONS-1:0]   spike_d;
  logic [N_NEURONS-1:0]   spike_rise;
  logic [N_NEURONS-1:0]   acc_mask;
  logic [N_NEURONS-1:0]   pend_eff;
  logic [N_NEURONS-1:0]   cap_ok;
  logic [N_NEURONS-1:0]   cap_set;
  logic [N_NEURONS-1:0]   cap_lost;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        pick_id;
  logic                   pick_vld;
  logic                   accept;
  logic [CNT_W-1:0]       cnt [N_NEURONS];

  assign ev_valid   = (state == OFFER);
  assign accept     = ev_valid & ev_ready;
  assign spike_rise = spike_in & ~spike_d;
  assign acc_mask   = accept ? (N_NEURONS'(1) << ev_id) : '0;
  // The neuron being accepted this cycle counts as already drained, so a
  // coincident edge on it is queued as a fresh event rather than lost.
  assign pend_eff   = pending & ~acc_mask;
  assign cap_ok     = ena ? (spike_rise & ~inhibit) : '0;
  assign cap_set    = cap_ok & ~pend_eff;
  assign cap_lost   = cap_ok & pend_eff;

  // Rotating priority search for the first pending neuron starting at rr_ptr.
  always_comb begin
    logic [ID_W-1:0] idx;
    pick_id  = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 0; k < N_NEURONS; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_NEURONS);
      if (!pick_vld && pending[idx]) begin
        pick_vld = 1'b1;
        pick_id  = idx;
      end
    end
  end

  // Next-state logic: offer when enabled with work queued, hold until accepted.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ena && pick_vld) state_nxt = OFFER;
      OFFER:   if (ev_ready)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Offered id latches on the IDLE->OFFER transition and stays put while offered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            ev_id <= '0;
    else if (state == IDLE && ena && pick_vld) ev_id <= pick_id;
  end

  // Round-robin pointer moves just past the neuron that was accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rr_ptr <= '0;
    else if (accept) rr_ptr <= (int'(ev_id) == N_NEURONS - 1) ? '0 : ev_id + ID_W'(1);
  end

  // Edge history runs regardless of ena so re-enabling never sees stale edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) spike_d <= '0;
    else        spike_d <= spike_in;
  end

  // Pending queue: drain on accept, fill on captured edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_eff | cap_set;
  end

  // Sticky overflow; a new loss wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          overflow <= 1'b0;
    else if (|cap_lost)  overflow <= 1'b1;
    else if (clr_ovf)    overflow <= 1'b0;
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_refrac
    // Refractory counter: load on accept, count down to zero, ignores ena.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt[g] <= '0;
      else if (acc_mask[g])      cnt[g] <= REFRAC_LD;
      else if (cnt[g] != '0)     cnt[g] <= cnt[g] - CNT_W'(1);
    end
    assign inhibit[g] = (cnt[g] != '0);
  end

endmodule

// File: tb/tb_spike_scheduler.sv
// Bench for spike_scheduler: directed scenarios plus a randomized run, all
// compared cycle by cycle against a behavioural event-queue model.
module tb_spike_scheduler;

  localparam int N      = 4;
  localparam int ID_W   = 2;
  localparam int REFRAC = 8;
  localparam int CNT_W  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            ena = 1'b0;
  logic [N-1:0]    spike_in = '0;
  logic            ev_valid;
  logic [ID_W-1:0] ev_id;
  logic            ev_ready = 1'b0;
  logic [N-1:0]    inhibit;
  logic [N-1:0]    pending;
  logic            overflow;
  logic            clr_ovf = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit [N-1:0] m_pend;
  int         m_refr [N];
  bit         m_ovf;
  int         m_rr;
  bit         m_offer;
  int         m_id;
  bit [N-1:0] m_prev;

  int dut_acc [$];

  always #5 clk = ~clk;

  spike_scheduler #(
    .N_NEURONS(N), .ID_W(ID_W), .REFRAC_CYCLES(REFRAC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .spike_in(spike_in),
    .ev_valid(ev_valid), .ev_id(ev_id), .ev_ready(ev_ready),
    .inhibit(inhibit), .pending(pending), .overflow(overflow), .clr_ovf(clr_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pend  = '0;
    m_ovf   = 1'b0;
    m_rr    = 0;
    m_offer = 1'b0;
    m_id    = 0;
    m_prev  = '0;
    for (int i = 0; i < N; i++) m_refr[i] = 0;
  endfunction

  // One clock of the event-queue view: who gets accepted, what gets queued or lost.
  function automatic void model_step(bit [N-1:0] sp, bit en, bit rdy, bit clr);
    bit [N-1:0] rise;
    bit [N-1:0] old_pend;
    bit [N-1:0] new_pend;
    bit         lost;
    int         took;
    rise     = sp & ~m_prev;
    old_pend = m_pend;
    new_pend = m_pend;
    lost     = 1'b0;
    took     = (m_offer && rdy) ? m_id : -1;
    for (int i = 0; i < N; i++) begin
      if (i == took) new_pend[i] = 1'b0;
      if (en && rise[i] && m_refr[i] == 0) begin
        if (new_pend[i]) lost = 1'b1;
        else             new_pend[i] = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (i == took)          m_refr[i] = REFRAC;
      else if (m_refr[i] > 0) m_refr[i] = m_refr[i] - 1;
    end
    if (m_offer) begin
      if (rdy) begin
        m_offer = 1'b0;
        m_rr    = (took + 1) % N;
      end
    end else if (en) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (old_pend[c]) begin
          m_id    = c;
          m_offer = 1'b1;
          break;
        end
      end
    end
    if (lost)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    m_pend = new_pend;
    m_prev = sp;
  endfunction

  task automatic compare_all();
    bit [N-1:0] e_inh;
    for (int i = 0; i < N; i++) e_inh[i] = (m_refr[i] != 0);
    check("ev_valid", ev_valid, m_offer);
    check("ev_id",    ev_id,    m_id);
    check("pending",  pending,  m_pend);
    check("inhibit",  inhibit,  e_inh);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic tick(input logic [N-1:0] sp, input logic en, input logic rdy, input logic clr);
    spike_in = sp;
    ena      = en;
    ev_ready = rdy;
    clr_ovf  = clr;
    #1;
    if (ev_valid && rdy) dut_acc.push_back(int'(ev_id));
    @(posedge clk);
    model_step(sp, en, rdy, clr);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    spike_in = '0; ena = 1'b0; ev_ready = 1'b0; clr_ovf = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_id",    ev_id,    0);
    check("rst_pending",  pending,  0);
    check("rst_inhibit",  inhibit,  0);
    check("rst_overflow", overflow, 0);
    #2 rst_n = 1'b1;
    dut_acc.delete();
  endtask

  initial begin
    int inh_len;
    logic [N-1:0] sp;

    // 1: single spike latency
    do_reset();
    repeat (3) tick(4'b0000, 1, 0, 0);
    tick(4'b0100, 1, 0, 0);
    check("t1_pending", pending, 4'b0100);
    check("t1_valid_early", ev_valid, 0);
    tick(4'b0100, 1, 0, 0);
    check("t1_valid", ev_valid, 1);
    check("t1_id", ev_id, 2);

    // 2: backpressure, then refractory length
    for (int i = 0; i < 10; i++) begin
      tick(4'b0100, 1, 0, 0);
      check("t2_hold_valid", ev_valid, 1);
      check("t2_hold_id", ev_id, 2);
    end
    tick(4'b0100, 1, 1, 0);
    check("t2_pend_clr", pending[2], 0);
    inh_len = int'(inhibit[2]);
    for (int i = 0; i < 9; i++) begin
      tick(4'b0100, 1, 0, 0);
      inh_len += int'(inhibit[2]);
    end
    check("t2_inhibit_len", inh_len, REFRAC);

    // 3: round robin order and pointer wrap
    do_reset();
    repeat (11) tick(4'b1011, 1, 1, 0);
    repeat (12) tick(4'b0000, 1, 1, 0);
    repeat (5)  tick(4'b0100, 1, 1, 0);
    repeat (8)  tick(4'b1101, 1, 1, 0);
    check("t3_count", dut_acc.size(), 6);
    if (dut_acc.size() == 6) begin
      check("t3_acc0", dut_acc[0], 0);
      check("t3_acc1", dut_acc[1], 1);
      check("t3_acc2", dut_acc[2], 3);
      check("t3_acc3", dut_acc[3], 2);
      check("t3_acc4", dut_acc[4], 3);
      check("t3_acc5", dut_acc[5], 0);
    end

    // 4: overflow, set-over-clear priority, clear
    do_reset();
    tick(4'b0010, 1, 0, 0);
    tick(4'b0000, 1, 0, 0);
    tick(4'b0010, 1, 0, 0);
    check("t4_ovf_set", overflow, 1);
    tick(4'b0000, 1, 0, 0);
    tick(4'b0010, 1, 0, 1);
    check("t4_ovf_prio", overflow, 1);
    tick(4'b0010, 1, 0, 1);
    check("t4_ovf_clr", overflow, 0);
    repeat (6) tick(4'b0000, 1, 1, 0);
    check("t4_one_event", dut_acc.size(), 1);

    // 5: refractory drop, ena gating, offer completes with ena low
    do_reset();
    repeat (3) tick(4'b0001, 1, 1, 0);
    tick(4'b0000, 1, 0, 0);
    tick(4'b0001, 1, 0, 0);
    check("t5_refr_pend", pending, 0);
    check("t5_refr_ovf", overflow, 0);
    repeat (10) tick(4'b0000, 0, 0, 0);
    tick(4'b0010, 0, 0, 0);
    check("t5_ena_pend", pending, 0);
    tick(4'b0010, 0, 0, 0);
    tick(4'b0110, 1, 0, 0);
    tick(4'b0110, 1, 0, 0);
    check("t5_offer", ev_valid, 1);
    repeat (3) tick(4'b0110, 0, 0, 0);
    check("t5_offer_hold", ev_valid, 1);
    tick(4'b0110, 0, 1, 0);
    check("t5_done", ev_valid, 0);
    check("t5_acc_count", dut_acc.size(), 2);
    if (dut_acc.size() == 2) check("t5_acc_id", dut_acc[1], 2);

    // 6: async reset while offering
    do_reset();
    tick(4'b1000, 1, 0, 0);
    tick(4'b1000, 1, 0, 0);
    check("t6_offer", ev_valid, 1);
    #2 rst_n = 1'b0;
    spike_in = '0;
    #1;
    check("t6_async_valid", ev_valid, 0);
    check("t6_async_id", ev_id, 0);
    check("t6_async_pend", pending, 0);
    check("t6_async_ovf", overflow, 0);
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) tick(4'b0000, 1, 1, 0);

    // Randomized run against the model
    do_reset();
    sp = '0;
    for (int i = 0; i < 600; i++) begin
      sp = sp ^ N'($urandom & $urandom);
      tick(sp, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
